// File: rtl/larpix_fifo_pkg.sv
// Shared definitions for the event FIFO: default geometry and the status flag bundle
// exported to the router and channel controllers.
package larpix_fifo_pkg;

    localparam int DEFAULT_WIDTH      = 64;
    localparam int DEFAULT_FIFO_DEPTH = 2048;

    typedef struct packed {
        logic empty;
        logic half;
        logic full;
        logic overflow;
    } fifo_flags_t;

endpackage

// File: rtl/fifo_ram.sv
// Packet storage for the event FIFO: synchronous write port, asynchronous read port
// so the head entry falls through to the transmitter without a read cycle.
module fifo_ram #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2048,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/event_fifo.sv
// First-word-fall-through event FIFO behind the router: edge-triggered writes with a
// one-cycle ack, sticky overflow on drops, and registered occupancy flags.
module event_fifo
    import larpix_fifo_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_event,
    output logic             fifo_ack,
    input  logic             read_fifo,
    output logic [WIDTH-1:0] data_out,
    output logic             fifo_empty,
    output logic             fifo_half,
    output logic             fifo_full,
    output logic [CNT_W-1:0] fifo_counter,
    output logic             fifo_overflow,
    input  logic             clear_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic             load_q_reg;
    logic             ack_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    fifo_flags_t      flags_reg;
    fifo_flags_t      flags_next;

    logic wr_req;
    logic is_full;
    logic is_empty;
    logic wr_accept;
    logic rd_accept;

    // Full/empty are judged on the occupancy before this cycle's traffic, so a pop
    // never makes room for a simultaneous write and a write never feeds a pop.
    assign wr_req    = load_event & ~load_q_reg;
    assign is_full   = (count_reg == CNT_W'(FIFO_DEPTH));
    assign is_empty  = (count_reg == '0);
    assign wr_accept = wr_req & ~is_full;
    assign rd_accept = read_fifo & ~is_empty;

    always_comb begin
        count_next = count_reg;
        if (wr_accept && !rd_accept) begin
            count_next = count_reg + CNT_W'(1);
        end else if (!wr_accept && rd_accept) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    // Flags come from next-state occupancy so they line up with fifo_counter.
    always_comb begin
        flags_next.empty    = (count_next == '0);
        flags_next.half     = (count_next >= CNT_W'(FIFO_DEPTH / 2));
        flags_next.full     = (count_next == CNT_W'(FIFO_DEPTH));
        flags_next.overflow = flags_reg.overflow;
        if (clear_overflow) begin
            flags_next.overflow = 1'b0;
        end
        if (wr_req && is_full) begin
            flags_next.overflow = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            load_q_reg <= 1'b0;
            ack_reg    <= 1'b0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            flags_reg  <= '{empty: 1'b1, half: 1'b0, full: 1'b0, overflow: 1'b0};
        end else begin
            load_q_reg <= load_event;
            ack_reg    <= wr_req;
            count_reg  <= count_next;
            flags_reg  <= flags_next;
            if (wr_accept) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (rd_accept) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_accept),
        .waddr (wr_ptr_reg),
        .wdata (data_in),
        .raddr (rd_ptr_reg),
        .rdata (data_out)
    );

    assign fifo_ack      = ack_reg;
    assign fifo_counter  = count_reg;
    assign fifo_empty    = flags_reg.empty;
    assign fifo_half     = flags_reg.half;
    assign fifo_full     = flags_reg.full;
    assign fifo_overflow = flags_reg.overflow;

endmodule

// File: tb/tb_event_fifo.sv
// Self-checking bench for event_fifo: directed vector table, hand-written corner
// sequences, and randomized traffic checked against a queue-based reference model.
module tb_event_fifo;

    localparam int W     = 64;
    localparam int DEPTH = 2048;
    localparam int CW    = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  data_in = '0;
    logic          load_event = 1'b0;
    logic          fifo_ack;
    logic          read_fifo = 1'b0;
    logic [W-1:0]  data_out;
    logic          fifo_empty;
    logic          fifo_half;
    logic          fifo_full;
    logic [CW-1:0] fifo_counter;
    logic          fifo_overflow;
    logic          clear_overflow = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a queue of accepted packets plus the handshake history.
    logic [W-1:0] mq[$];
    logic         m_prev_load = 1'b0;
    logic         m_ack = 1'b0;
    logic         m_ovf = 1'b0;

    event_fifo #(.WIDTH(W), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .data_in        (data_in),
        .load_event     (load_event),
        .fifo_ack       (fifo_ack),
        .read_fifo      (read_fifo),
        .data_out       (data_out),
        .fifo_empty     (fifo_empty),
        .fifo_half      (fifo_half),
        .fifo_full      (fifo_full),
        .fifo_counter   (fifo_counter),
        .fifo_overflow  (fifo_overflow),
        .clear_overflow (clear_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_update(input logic rst, input logic ld, input logic [W-1:0] d,
                                input logic rd, input logic clr);
        logic wr;
        logic was_full;
        logic was_empty;
        if (rst) begin
            mq.delete();
            m_prev_load = 1'b0;
            m_ack = 1'b0;
            m_ovf = 1'b0;
        end else begin
            wr = ld && !m_prev_load;
            m_prev_load = ld;
            was_full  = (mq.size() == DEPTH);
            was_empty = (mq.size() == 0);
            m_ack = wr;
            if (rd && !was_empty) void'(mq.pop_front());
            if (wr && !was_full) mq.push_back(d);
            if (clr) m_ovf = 1'b0;
            if (wr && was_full) m_ovf = 1'b1;
        end
    endtask

    // One clock: drive, let the edge happen, advance the model, compare 1 ns later.
    task automatic step(input logic rst, input logic ld, input logic [W-1:0] d,
                        input logic rd, input logic clr);
        int sz;
        logic [16:0] exp_st;
        logic [16:0] act_st;
        reset = rst; load_event = ld; data_in = d; read_fifo = rd; clear_overflow = clr;
        @(posedge clk);
        model_update(rst, ld, d, rd, clr);
        #1;
        sz = mq.size();
        exp_st = {m_ack, m_ovf, sz == DEPTH, sz >= DEPTH / 2, sz == 0, CW'(sz)};
        act_st = {fifo_ack, fifo_overflow, fifo_full, fifo_half, fifo_empty, fifo_counter};
        check("status{ack,ovf,full,half,empty,cnt}", 64'(act_st), 64'(exp_st));
        if (sz > 0) check("data_out", data_out, mq[0]);
    endtask

    task automatic write_pkt(input logic [W-1:0] d);
        step(1'b0, 1'b1, d, 1'b0, 1'b0);
        step(1'b0, 1'b0, d, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic          ld;
        logic [W-1:0]  din;
        logic          rd;
        logic          ack;
        logic [CW-1:0] cnt;
        logic          empty;
        logic [W-1:0]  dout;
    } vec_t;

    vec_t vt[12];

    initial begin
        logic [W-1:0] pa, pb, pc, rnd;
        pa = 64'hDEAD_BEEF_0000_0001;
        pb = 64'h0123_4567_89AB_CDEF;
        pc = 64'hFEDC_BA98_7654_3210;
        vt[0]  = '{1'b1, pa, 1'b0, 1'b1, 12'd1, 1'b0, pa};
        vt[1]  = '{1'b1, pa, 1'b0, 1'b0, 12'd1, 1'b0, pa};
        vt[2]  = '{1'b1, pa, 1'b0, 1'b0, 12'd1, 1'b0, pa};
        vt[3]  = '{1'b1, pa, 1'b0, 1'b0, 12'd1, 1'b0, pa};
        vt[4]  = '{1'b1, pa, 1'b0, 1'b0, 12'd1, 1'b0, pa};
        vt[5]  = '{1'b0, pa, 1'b0, 1'b0, 12'd1, 1'b0, pa};
        vt[6]  = '{1'b0, pa, 1'b1, 1'b0, 12'd0, 1'b1, '0};
        vt[7]  = '{1'b0, pa, 1'b1, 1'b0, 12'd0, 1'b1, '0};
        vt[8]  = '{1'b1, pb, 1'b1, 1'b1, 12'd1, 1'b0, pb};
        vt[9]  = '{1'b0, pb, 1'b0, 1'b0, 12'd1, 1'b0, pb};
        vt[10] = '{1'b1, pc, 1'b1, 1'b1, 12'd1, 1'b0, pc};
        vt[11] = '{1'b0, pc, 1'b1, 1'b0, 12'd0, 1'b1, '0};

        // Reset state
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        check("reset_empty", 64'(fifo_empty), 64'd1);
        check("reset_cnt", 64'(fifo_counter), 64'd0);

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            step(1'b0, vt[i].ld, vt[i].din, vt[i].rd, 1'b0);
            check($sformatf("vec%0d_ack", i), 64'(fifo_ack), 64'(vt[i].ack));
            check($sformatf("vec%0d_cnt", i), 64'(fifo_counter), 64'(vt[i].cnt));
            check($sformatf("vec%0d_empty", i), 64'(fifo_empty), 64'(vt[i].empty));
            if (!vt[i].empty) check($sformatf("vec%0d_dout", i), data_out, vt[i].dout);
        end

        // Fill to half, full, then overflow and clear
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            write_pkt(64'(i) ^ 64'hA5A5_0000_0000_0000);
            if (i == DEPTH / 2 - 2) check("half_at_1023", 64'(fifo_half), 64'd0);
            if (i == DEPTH / 2 - 1) check("half_at_1024", 64'(fifo_half), 64'd1);
            if (i == DEPTH - 2) check("full_at_2047", 64'(fifo_full), 64'd0);
        end
        check("full_at_2048", 64'(fifo_full), 64'd1);
        check("cnt_full", 64'(fifo_counter), 64'd2048);
        step(1'b0, 1'b1, 64'h1111, 1'b0, 1'b0);
        check("ovf_ack", 64'(fifo_ack), 64'd1);
        check("ovf_cnt", 64'(fifo_counter), 64'd2048);
        check("ovf_set", 64'(fifo_overflow), 64'd1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        check("ovf_cleared", 64'(fifo_overflow), 64'd0);
        step(1'b0, 1'b1, 64'h2222, 1'b0, 1'b1);
        check("ovf_set_wins", 64'(fifo_overflow), 64'd1);
        // Drop while full even with a same-cycle pop
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 64'h3333, 1'b1, 1'b0);
        check("full_pop_drop_cnt", 64'(fifo_counter), 64'd2047);
        check("full_pop_drop_ovf", 64'(fifo_overflow), 64'd1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("drained_empty", 64'(fifo_empty), 64'd1);

        // Ordered write/read of ten packets and an extra pop on empty
        for (int i = 0; i < 10; i++) write_pkt(64'(i));
        for (int i = 0; i < 10; i++) begin
            check($sformatf("order_%0d", i), data_out, 64'(i));
            step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        end
        check("ten_empty", 64'(fifo_empty), 64'd1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("extra_pop_cnt", 64'(fifo_counter), 64'd0);

        // Steady occupancy 3 with simultaneous write and pop, across pointer wrap
        for (int i = 0; i < 3; i++) write_pkt({32'hC0DE_0000, 32'(i)});
        for (int i = 3; i < 3000; i++) begin
            step(1'b0, 1'b1, {32'hC0DE_0000, 32'(i)}, 1'b1, 1'b0);
            check("occ3_cnt", 64'(fifo_counter), 64'd3);
            step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        end
        check("occ3_head", data_out, {32'hC0DE_0000, 32'd2997});

        // Reset mid-handshake, then load held high is a rising edge after reset
        step(1'b0, 1'b1, 64'h4444, 1'b0, 1'b0);
        check("pre_rst_ack", 64'(fifo_ack), 64'd1);
        step(1'b1, 1'b1, 64'h4444, 1'b0, 1'b0);
        check("rst_ack", 64'(fifo_ack), 64'd0);
        check("rst_cnt", 64'(fifo_counter), 64'd0);
        check("rst_empty", 64'(fifo_empty), 64'd1);
        step(1'b0, 1'b1, 64'h5555, 1'b0, 1'b0);
        check("post_rst_ack", 64'(fifo_ack), 64'd1);
        check("post_rst_dout", data_out, 64'h5555);

        // Randomized traffic against the model
        for (int i = 0; i < 5000; i++) begin
            rnd = {$urandom, $urandom};
            step(1'b0, 1'($urandom_range(0, 1)), rnd, ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 15) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
